// File: rtl/host_mem_loader.sv
//==============================================================================
// Module   : host_mem_loader
// Purpose  : Streaming host-to-memory transfer engine. A header word selects
//            a base address, a word count and a direction. Writes store the
//            following payload words at auto-incrementing addresses. Reads
//            stream the addressed range back over a valid/ready port.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            in_valid/in_ready/in_data    - host header/payload stream
//            out_valid/out_ready/out_data - readback stream
//            mem_wr_en/mem_rd_en/mem_addr/mem_wdata/mem_rdata - memory port
//            busy, done, err         - transfer status
// Options  : LOADER_CHECKSUM_EN - writes take a trailing checksum word, which
//            is compared with the sum of the payload. Reads emit a trailing
//            word equal to the sum of the words read.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module host_mem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_OUT   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,S_CHECK   = 3'd5
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;        // next address to access
    logic [CNT_W-1:0]  r_remaining;   // words still to write / to fetch
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_mem_wr_en;
    logic              r_mem_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_sum_sent;    // trailing read checksum already emitted
`endif

    logic [ADDR_W-1:0] w_hdr_base;
    logic [CNT_W-1:0]  w_hdr_count;
    logic              w_hdr_dir;
    logic              w_in_accept_state;
    logic              w_in_fire;
    logic              w_unused_hdr;

    assign w_hdr_base   = in_data[ADDR_W-1:0];
    assign w_hdr_count  = in_data[2*ADDR_W:ADDR_W];
    assign w_hdr_dir    = in_data[DATA_W-1];
    // Header bits between count and dir carry no meaning.
    assign w_unused_hdr = ^in_data;

`ifdef LOADER_CHECKSUM_EN
    assign w_in_accept_state = (r_state == S_IDLE) || (r_state == S_WRITE) ||
                               (r_state == S_CHECK);
`else
    assign w_in_accept_state = (r_state == S_IDLE) || (r_state == S_WRITE);
`endif

    // Decoded from state; also held low while reset is asserted so the host
    // cannot hand over a word that the reset is about to discard.
    assign in_ready  = w_in_accept_state && !reset;
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_sum_sent  <= 1'b0;
`endif
        end else begin
            r_mem_wr_en <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_err <= 1'b0;
                        if (w_hdr_count == '0) begin
                            r_done <= 1'b1;
                        end else if (w_hdr_count > C_DEPTH) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_busy      <= 1'b1;
                            r_remaining <= w_hdr_count;
`ifdef LOADER_CHECKSUM_EN
                            r_sum       <= '0;
                            r_sum_sent  <= 1'b0;
`endif
                            if (w_hdr_dir) begin
                                // Strobe launched on entry so it is visible
                                // during the RD_ISSUE cycle.
                                r_mem_rd_en <= 1'b1;
                                r_mem_addr  <= w_hdr_base;
                                r_addr      <= w_hdr_base + 1'b1;
                                r_state     <= S_RD_ISSUE;
                            end else begin
                                r_addr  <= w_hdr_base;
                                r_state <= S_WRITE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (w_in_fire) begin
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= in_data;
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum       <= r_sum + in_data;
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= S_CHECK;
                        end
`else
                        if (r_remaining == CNT_W'(1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_in_fire) begin
                        if (in_data != r_sum) begin
                            r_err <= 1'b1;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_out_data  <= mem_rdata;
                    r_out_valid <= 1'b1;
                    r_remaining <= r_remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_sum       <= r_sum + mem_rdata;
`endif
                    r_state     <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_remaining != '0) begin
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_addr;
                            r_addr      <= r_addr + 1'b1;
                            r_state     <= S_RD_ISSUE;
`ifdef LOADER_CHECKSUM_EN
                        end else if (!r_sum_sent) begin
                            // Trailing checksum word follows back-to-back.
                            r_out_data  <= r_sum;
                            r_out_valid <= 1'b1;
                            r_sum_sent  <= 1'b1;
`endif
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign mem_wr_en = r_mem_wr_en;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_host_mem_loader.sv
//==============================================================================
// Module   : tb_host_mem_loader
// Purpose  : Directed self-checking bench for host_mem_loader with a simple
//            one-cycle-latency memory model on the memory port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_host_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q [0:3];
    int          n_tests = 0;
    int          n_fail  = 0;

    host_mem_loader #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory model: registered read data, valid the cycle after mem_rd_en.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic dir, input logic [5:0] base,
                                        input logic [6:0] cnt);
        hdr = {dir, 18'd0, cnt, base};
    endfunction

    // Header then n payload words from exp_q, back-to-back.
    task automatic write_burst(input logic [5:0] base, input int n);
        logic [5:0] a;
        in_valid = 1'b1;
        in_data  = hdr(1'b0, base, 7'(n));
        step();
        chk("wr_hdr_busy", busy, 1);
        chk("wr_hdr_no_strobe", mem_wr_en, 0);
        a = base;
        for (int i = 0; i < n; i++) begin
            in_data = exp_q[i];
            step();
            chk("wr_en", mem_wr_en, 1);
            chk("wr_addr", mem_addr, a);
            chk("wr_data", mem_wdata, exp_q[i]);
            chk("wr_done", done, (i == n - 1));
            chk("wr_busy", busy, (i != n - 1));
            a = a + 6'd1;
        end
        in_valid = 1'b0;
        chk("wr_err", err, 0);
        step();
        chk("wr_after_en", mem_wr_en, 0);
        chk("wr_after_done", done, 0);
    endtask

    // Read n words from base, expecting exp_q; out_ready toggles 0/1.
    task automatic read_burst(input logic [5:0] base, input int n);
        int  idx;
        bit  got_done;
        in_valid = 1'b1;
        in_data  = hdr(1'b1, base, 7'(n));
        step();
        in_valid = 1'b0;
        chk("rd_issue_en", mem_rd_en, 1);
        chk("rd_issue_addr", mem_addr, base);
        chk("rd_in_ready", in_ready, 0);
        chk("rd_ov_n1", out_valid, 0);
        step();
        chk("rd_ov_n2", out_valid, 0);
        chk("rd_en_n2", mem_rd_en, 0);
        step();
        chk("rd_ov_n3", out_valid, 1);
        idx = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
            out_ready = cyc[0];
            if (out_valid) begin
                chk("rd_data", out_data, exp_q[idx]);
                if (out_ready) idx++;
            end
            if (done) begin
                chk("rd_done_count", idx, n);
                chk("rd_done_busy", busy, 0);
                got_done = 1'b1;
            end
            if (!got_done) step();
        end
        out_ready = 1'b0;
        chk("rd_timeout", got_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;

        // Reset values
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        step();
        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Write 0x11..0x44 at 0..3, read back with stalls
        exp_q[0] = 32'h11; exp_q[1] = 32'h22; exp_q[2] = 32'h33; exp_q[3] = 32'h44;
        write_burst(6'd0, 4);
        read_burst(6'd0, 4);

        // Wrap-around write 62,63,0,1 and read back across the wrap
        exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2; exp_q[3] = 32'hA3;
        write_burst(6'd62, 4);
        read_burst(6'd62, 4);

        // count = 0: done next cycle, no strobe, no busy
        step();
        in_valid = 1'b1;
        in_data  = hdr(1'b0, 6'd5, 7'd0);
        step();
        in_valid = 1'b0;
        chk("nop_done", done, 1);
        chk("nop_busy", busy, 0);
        chk("nop_wr_en", mem_wr_en, 0);
        chk("nop_err", err, 0);
        step();
        chk("nop_done_clear", done, 0);
        chk("nop_in_ready", in_ready, 1);

        // count = DEPTH+1: err + done, no strobe
        in_valid = 1'b1;
        in_data  = hdr(1'b1, 6'd0, 7'd65);
        step();
        in_valid = 1'b0;
        chk("big_err", err, 1);
        chk("big_done", done, 1);
        chk("big_rd_en", mem_rd_en, 0);
        chk("big_busy", busy, 0);
        step();
        chk("big_err_sticky", err, 1);
        chk("big_done_clear", done, 0);
        chk("big_no_strobe", mem_rd_en, 0);

        // Next valid header clears err; single-word write at 10
        in_valid = 1'b1;
        in_data  = hdr(1'b0, 6'd10, 7'd1);
        step();
        chk("clr_err", err, 0);
        chk("clr_busy", busy, 1);
        in_data = 32'h55;
        step();
        in_valid = 1'b0;
        chk("one_wr_en", mem_wr_en, 1);
        chk("one_wr_addr", mem_addr, 10);
        chk("one_done", done, 1);
        step();

        // Reset after 2 of 4 write words
        in_valid = 1'b1;
        in_data  = hdr(1'b0, 6'd20, 7'd4);
        step();
        in_data = 32'h61;
        step();
        in_data = 32'h62;
        step();
        chk("abort_pre_wr", mem_wr_en, 1);
        reset   = 1'b1;
        in_data = 32'h63;
        step();
        chk("abort_in_ready", in_ready, 0);
        chk("abort_wr_en", mem_wr_en, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("abort_idle_ready", in_ready, 1);
        chk("abort_idle_wr", mem_wr_en, 0);
        chk("abort_idle_busy", busy, 0);
        exp_q[0] = 32'h61; exp_q[1] = 32'h62; exp_q[2] = 32'h0;
        read_burst(6'd20, 3);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
